ff_add_255: RTL and testbench
=============================

Name: ff_add_255

Overview:
- Registered modular adder over the Curve25519 prime field, P = 2^255 - 19.
- Computes result = (a + b) mod P, always fully reduced into [0, P-1].
- Used as the field-addition primitive inside the ECC scalar-multiplication datapath.
- Free-running: samples its inputs every clock and has a fixed latency of 1 cycle.

Parameters:
- LIMB_W, 51: segment width of the internal carry-select adder chains. Must divide 255 exactly. Has no functional effect; it only controls timing and area.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-low reset. When rst = 0 at a rising clk edge, the block resets.
- a, input, 255: first operand, any value in [0, 2^255-1].
- b, input, 255: second operand, any value in [0, 2^255-1].
- result, output, 255: (a + b) mod P, registered.
- valid, output, 1: result holds a reduced sum of sampled inputs, registered.

Behaviour:
- Reset: on a clk edge with rst = 0, result <= 0 and valid <= 0. Reset mid-operation discards any in-flight value with no partial update.
- Operation: on every clk edge with rst = 1:
  - result <= (a + b) mod P, using the a and b sampled at that same edge.
  - valid <= 1.
- Latency is exactly 1 cycle. Inputs applied before edge N are visible on result after edge N.
- Throughput is one operation per cycle; there is no back-pressure.
- valid stays 1 continuously while rst = 1. It drops only on reset.
- Arithmetic:
  - s = a + b, 256 bits wide, no loss of carry.
  - d1 = s - P and d2 = s - 2P, each 257 bits signed (borrow kept).
  - Select d2 if d2 >= 0, else d1 if d1 >= 0, else s.
  - Output the low 255 bits.
  - Because s <= 2^256 - 2 and 2P = 2^256 - 38, the result is always < P. Non-canonical inputs (>= P) are therefore also fully reduced.
- Boundaries:
  - s == P gives 0.
  - s == 2P gives 0.
  - s == P-1 passes through unchanged.
  - a = b = 2^255-1 gives 36.
- All logic is combinational between the input sample and the single output register. There is no internal state other than result and valid.

Optional Feature:
- Macro: FF_ADD_255_SUB_EN.
- When defined:
  - Adds input port `sub` (1 bit), sampled with a and b.
  - sub = 1 gives result <= (a - b) mod P.
  - Subtraction method: compute t = a - b (signed), then add P or 2P as needed to land in [0, P-1]. Inputs in [0, 2^255-1] therefore still reduce fully.
  - sub = 0 gives addition as above.
  - Latency, reset and valid behaviour are identical to addition.
- When undefined: the `sub` port does not exist and the block is add-only.

Decomposition:
- Package ff25519_pkg holds:
  - FE_W = 255;
  - P_CONST = 2^255 - 19;
  - P2_CONST = 2^256 - 38;
  - typedef fe_t (255-bit logic vector).
- Sub-module ff_csel_adder: a parameterised LIMB_W-segmented carry-select adder/subtractor that returns sum and carry/borrow.
  - Instantiated three times: s, d1 and d2. With FF_ADD_255_SUB_EN defined, the subtract-path terms reuse the same instances.

Test Plan:
- rst = 0 for 2 edges: result = 0 and valid = 0. Release, apply a = 10, b = 20: after 1 edge, valid = 1 and result = 30.
- a = 2^254, b = 1: result = 2^254 + 1 after 1 edge, with no reduction.
- a = P-1, b = 4686: result = 4685. a = P-1, b = 1: result = 0. a = P-1, b = 0: result = P-1.
- a = b = 2^255-1: result = 36. a = P, b = P: result = 0.
- Back-to-back vectors on consecutive cycles (10+20, P-1+2, 5+7): outputs 30, 1, 12 on consecutive cycles with valid held at 1. Assert rst = 0 mid-stream: the next edge gives result = 0 and valid = 0.
- With FF_ADD_255_SUB_EN defined and sub = 1:
  - a = 5, b = 7 gives result = P-2.
  - a = 0, b = 2^255-1 gives result = P-18.
  - a = 30, b = 20 gives result = 10.

Source files
------------

// File: rtl/ff25519_pkg.sv
// ---------------------------------------------------------------------------
// ff25519_pkg
//
// Purpose : shared constants and types for arithmetic over the Curve25519
//           prime field, P = 2^255 - 19.
//
// Contents:
//   FE_W      - field element width (255 bits)
//   P_CONST   - the prime P = 2^255 - 19
//   P2_CONST  - 2P = 2^256 - 38 (256 bits)
//   P2_LO     - low 255 bits of 2P (= 2^255 - 38); bit 255 of 2P is 1
//   fe_t      - 255-bit field element vector
// ---------------------------------------------------------------------------
package ff25519_pkg;

  localparam int FE_W = 255;

  typedef logic [FE_W-1:0] fe_t;

  // 2^255 - 19: every bit set except those of 18 (binary 10010) in the low
  // five bits, i.e. low five bits are 01101.
  localparam logic [FE_W-1:0] P_CONST = {{(FE_W-5){1'b1}}, 5'b01101};

  // 2P = P shifted left by one.
  localparam logic [FE_W:0] P2_CONST = {P_CONST, 1'b0};

  // Low 255 bits of 2P; the implicit bit 255 of 2P is handled by the
  // caller when it forms the sign of s - 2P.
  localparam logic [FE_W-1:0] P2_LO = P2_CONST[FE_W-1:0];

endpackage : ff25519_pkg

// File: rtl/ff_csel_adder.sv
// ---------------------------------------------------------------------------
// ff_csel_adder
//
// Purpose : W-bit adder/subtractor built from W/LIMB_W carry-select
//           segments. Each segment precomputes its sum for carry-in 0 and 1
//           and the incoming carry picks one, so the carry only ripples
//           through one mux per segment.
//
// Parameters:
//   W       - operand width
//   LIMB_W  - segment width; must divide W exactly
//
// Ports:
//   a_i     - in,  W : first operand
//   b_i     - in,  W : second operand
//   sub_i   - in,  1 : 0 = a + b, 1 = a - b (two's complement: a + ~b + 1)
//   sum_o   - out, W : low W bits of the result
//   carry_o - out, 1 : raw carry out of the top segment. For subtraction a
//                      borrow occurred (a < b) exactly when carry_o = 0.
// ---------------------------------------------------------------------------
module ff_csel_adder #(
  parameter int W      = 255,
  parameter int LIMB_W = 51
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  localparam int NSEG = W / LIMB_W;

  logic [W-1:0]  b_eff_s;
  logic [NSEG:0] seg_c_s;

  // Subtraction inverts b and injects the +1 as the chain carry-in.
  assign b_eff_s    = sub_i ? ~b_i : b_i;
  assign seg_c_s[0] = sub_i;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    logic [LIMB_W:0] sum0_s;
    logic [LIMB_W:0] sum1_s;

    // Both candidate sums; sum0 is at most 2^(LIMB_W+1)-2 so +1 cannot wrap.
    assign sum0_s = {1'b0, a_i[g*LIMB_W +: LIMB_W]}
                  + {1'b0, b_eff_s[g*LIMB_W +: LIMB_W]};
    assign sum1_s = sum0_s + {{LIMB_W{1'b0}}, 1'b1};

    assign sum_o[g*LIMB_W +: LIMB_W] = seg_c_s[g] ? sum1_s[LIMB_W-1:0]
                                                  : sum0_s[LIMB_W-1:0];
    assign seg_c_s[g+1] = seg_c_s[g] ? sum1_s[LIMB_W] : sum0_s[LIMB_W];
  end

  assign carry_o = seg_c_s[NSEG];

endmodule : ff_csel_adder

// File: rtl/ff_add_255.sv
// ---------------------------------------------------------------------------
// ff_add_255
//
// Purpose : registered modular adder over GF(2^255 - 19). Every clock with
//           rst high it samples a and b and registers (a + b) mod P, fully
//           reduced into [0, P-1]. Latency is one cycle, throughput one per
//           cycle, no back-pressure.
//
// Configuration macro:
//   FF_ADD_255_SUB_EN - when defined adds input `sub`; sub = 1 registers
//                       (a - b) mod P instead. Undefined: add-only block.
//
// Parameters:
//   LIMB_W  - carry-select segment width (must divide 255); timing only.
//
// Ports:
//   clk     - in,  1   : rising-edge clock
//   rst     - in,  1   : synchronous active-low reset
//   sub     - in,  1   : (FF_ADD_255_SUB_EN only) 1 = subtract
//   a       - in,  255 : first operand, any value in [0, 2^255-1]
//   b       - in,  255 : second operand, any value in [0, 2^255-1]
//   result  - out, 255 : reduced sum/difference, registered
//   valid   - out, 1   : result holds a reduced value of sampled inputs
// ---------------------------------------------------------------------------
module ff_add_255
  import ff25519_pkg::*;
#(
  parameter int LIMB_W = 51
) (
  input  logic         clk,
  input  logic         rst,
`ifdef FF_ADD_255_SUB_EN
  input  logic         sub,
`endif
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic [254:0] result,
  output logic         valid
);

  // -------------------------------------------------------------------------
  // Operation select
  // -------------------------------------------------------------------------
  logic sub_s;

`ifdef FF_ADD_255_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Stage 0: raw sum / difference.
  //   add: s = {co0, r0}, a 256-bit sum with no carry lost.
  //   sub: t = a - b; co0 = 0 means t is negative, r0 = t mod 2^255.
  // -------------------------------------------------------------------------
  fe_t  r0_s;
  logic co0_s;

  ff_csel_adder #(.W(FE_W), .LIMB_W(LIMB_W)) u_s (
    .a_i     (a),
    .b_i     (b),
    .sub_i   (sub_s),
    .sum_o   (r0_s),
    .carry_o (co0_s)
  );

  // -------------------------------------------------------------------------
  // Stage 1 candidate (d1):
  //   add            : r0 - P  ; s - P >= 0  iff  co0 | co1
  //   sub, t >= 0    : r0 - P  ; t >= P      iff  co1
  //   sub, t <  0    : r0 + P  ; t + P >= 0  iff  co1 (overflow past 2^255
  //                    cancels the -2^255 carried in r0's representation)
  // -------------------------------------------------------------------------
  fe_t  r1_s;
  logic co1_s;
  logic d1_sub_s;

  assign d1_sub_s = ~(sub_s & ~co0_s);

  ff_csel_adder #(.W(FE_W), .LIMB_W(LIMB_W)) u_d1 (
    .a_i     (r0_s),
    .b_i     (P_CONST),
    .sub_i   (d1_sub_s),
    .sum_o   (r1_s),
    .carry_o (co1_s)
  );

  // -------------------------------------------------------------------------
  // Stage 2 candidate (d2). 2P = 2^255 + P2_LO, so only the low part goes
  // through the adder and bit 255 is folded into the sign test:
  //   add : s - 2P >= 0  iff  co0 & co1_of(r0 - P2_LO)
  //   sub : t + 2P = r0 + P2_LO (the 2^255 terms cancel); only used when
  //         t + P < 0, where t + 2P lies in [P-18, P-1].
  // -------------------------------------------------------------------------
  fe_t  r2_s;
  logic co2_s;
  logic d2_sub_s;

  assign d2_sub_s = ~sub_s;

  ff_csel_adder #(.W(FE_W), .LIMB_W(LIMB_W)) u_d2 (
    .a_i     (r0_s),
    .b_i     (P2_LO),
    .sub_i   (d2_sub_s),
    .sum_o   (r2_s),
    .carry_o (co2_s)
  );

  // -------------------------------------------------------------------------
  // Candidate selection
  // -------------------------------------------------------------------------
  fe_t  result_d;
  logic d1_ok_s;
  logic d2_ok_s;

  // Picks the unique in-range candidate for the current operation.
  always_comb begin
    result_d = r0_s;
    d1_ok_s  = 1'b0;
    d2_ok_s  = 1'b0;
    if (sub_s) begin
      if (!co0_s) begin
        // t < 0: add P if that suffices, otherwise add 2P.
        d1_ok_s = co1_s;
        if (d1_ok_s) begin
          result_d = r1_s;
        end else begin
          result_d = r2_s;
        end
      end else begin
        // t >= 0 and t < 2^255 < 2P: at most one subtraction of P.
        d1_ok_s = co1_s;
        if (d1_ok_s) begin
          result_d = r1_s;
        end else begin
          result_d = r0_s;
        end
      end
    end else begin
      d2_ok_s = co0_s & co2_s;
      d1_ok_s = co0_s | co1_s;
      if (d2_ok_s) begin
        result_d = r2_s;
      end else if (d1_ok_s) begin
        result_d = r1_s;
      end else begin
        result_d = r0_s;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  fe_t  result_q;
  logic valid_q;

  // Single pipeline register; reset discards whatever was in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= 1'b1;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;

endmodule : ff_add_255

// File: tb/tb_ff_add_255.sv
// ---------------------------------------------------------------------------
// tb_ff_add_255
//
// Directed self-checking bench for ff_add_255. Inputs are driven 1 time
// unit after a rising edge and outputs sampled 1 time unit after the next.
// Subtraction vectors are included when FF_ADD_255_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_ff_add_255;

  localparam logic [255:0] TWO255 = 256'd1 << 255;
  localparam logic [254:0] PV     = 255'(TWO255 - 256'd19);
  localparam logic [254:0] MAXV   = 255'(TWO255 - 256'd1);
  localparam logic [254:0] TWO254 = 255'(256'd1 << 254);

  logic         clk;
  logic         rst;
  logic [254:0] a;
  logic [254:0] b;
  logic [254:0] result;
  logic         valid;
`ifdef FF_ADD_255_SUB_EN
  logic         sub;
`endif

  int errors;
  int checks;

  ff_add_255 dut (
    .clk    (clk),
    .rst    (rst),
`ifdef FF_ADD_255_SUB_EN
    .sub    (sub),
`endif
    .a      (a),
    .b      (b),
    .result (result),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a   = 255'd123;
    b   = 255'd456;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (result !== 255'd0) begin
        errors++;
        $display("FAIL reset_result[%0d]: got %h want 0", i, result);
      end
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid[%0d]: got %b want 0", i, valid);
      end
    end
    rst = 1'b1;
    a   = 255'd10;
    b   = 255'd20;
    step();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL first_valid: got %b want 1", valid);
    end
    checks++;
    if (result !== 255'd30) begin
      errors++;
      $display("FAIL first_result: got %h want %h", result, 255'd30);
    end
  endtask

  task automatic test_boundaries();
    logic [254:0] va [8];
    logic [254:0] vb [8];
    logic [254:0] ve [8];
    va[0] = TWO254;      vb[0] = 255'd1;     ve[0] = TWO254 + 255'd1;
    va[1] = PV - 255'd1; vb[1] = 255'd4686;  ve[1] = 255'd4685;
    va[2] = PV - 255'd1; vb[2] = 255'd1;     ve[2] = 255'd0;
    va[3] = PV - 255'd1; vb[3] = 255'd0;     ve[3] = PV - 255'd1;
    va[4] = MAXV;        vb[4] = MAXV;       ve[4] = 255'd36;
    va[5] = PV;          vb[5] = PV;         ve[5] = 255'd0;
    va[6] = PV - 255'd1; vb[6] = PV - 255'd1; ve[6] = PV - 255'd2;
    va[7] = 255'd7;      vb[7] = PV;         ve[7] = 255'd7;
    for (int i = 0; i < 8; i++) begin
      a = va[i];
      b = vb[i];
      step();
      checks++;
      if (result !== ve[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL boundary[%0d]: got %h v=%b want %h v=1",
                 i, result, valid, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [254:0] va [3];
    logic [254:0] vb [3];
    logic [254:0] ve [3];
    va[0] = 255'd10;     vb[0] = 255'd20; ve[0] = 255'd30;
    va[1] = PV - 255'd1; vb[1] = 255'd2;  ve[1] = 255'd1;
    va[2] = 255'd5;      vb[2] = 255'd7;  ve[2] = 255'd12;
    for (int i = 0; i < 3; i++) begin
      a = va[i];
      b = vb[i];
      step();
      checks++;
      if (result !== ve[i]) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got %h want %h", i, result, ve[i]);
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid);
      end
    end
    // Mid-stream reset with a live vector on the inputs.
    rst = 1'b0;
    a   = 255'd100;
    b   = 255'd200;
    step();
    checks++;
    if (result !== 255'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got %h v=%b want 0 v=0", result, valid);
    end
    rst = 1'b1;
    step();
    checks++;
    if (result !== 255'd300 || valid !== 1'b1) begin
      errors++;
      $display("FAIL after_midreset: got %h v=%b want %h v=1",
               result, valid, 255'd300);
    end
  endtask

`ifdef FF_ADD_255_SUB_EN
  task automatic test_sub();
    logic [254:0] va [4];
    logic [254:0] vb [4];
    logic [254:0] ve [4];
    va[0] = 255'd5;  vb[0] = 255'd7;   ve[0] = PV - 255'd2;
    va[1] = 255'd0;  vb[1] = MAXV;     ve[1] = PV - 255'd18;
    va[2] = 255'd30; vb[2] = 255'd20;  ve[2] = 255'd10;
    va[3] = MAXV;    vb[3] = 255'd0;   ve[3] = 255'd18;
    sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i];
      b = vb[i];
      step();
      checks++;
      if (result !== ve[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL sub[%0d]: got %h v=%b want %h v=1",
                 i, result, valid, ve[i]);
      end
    end
    sub = 1'b0;
    a   = 255'd30;
    b   = 255'd20;
    step();
    checks++;
    if (result !== 255'd50) begin
      errors++;
      $display("FAIL sub_off_add: got %h want %h", result, 255'd50);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    a      = '0;
    b      = '0;
`ifdef FF_ADD_255_SUB_EN
    sub    = 1'b0;
`endif
    #1;
    test_reset();
    test_boundaries();
    test_back_to_back();
`ifdef FF_ADD_255_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ff_add_255
